// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors match controller:
// one-hot move encodings, result codes, FSM states and a move validity helper.
// Optional feature macro used by the controller: RPS_TIMEOUT_EN.
package rps_pkg;

   localparam logic [2:0] MOVE_PAPER    = 3'b100;
   localparam logic [2:0] MOVE_ROCK     = 3'b010;
   localparam logic [2:0] MOVE_SCISSORS = 3'b001;

   typedef enum logic [1:0] {
      RES_DRAW  = 2'b00,
      RES_A_WIN = 2'b01,
      RES_B_WIN = 2'b10,
      RES_VOID  = 2'b11
   } res_code_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_JUDGE   = 3'd2,
      ST_REPORT  = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // A move is legal only when it is exactly one of the three one-hot codes.
   function automatic logic is_legal_move(input logic [2:0] m);
      return (m == MOVE_PAPER) || (m == MOVE_ROCK) || (m == MOVE_SCISSORS);
   endfunction

endpackage

// File: rtl/rps_match_ctrl_if.sv
// Handshake and status bundle between a match host and rps_match_ctrl.
// master = host side (drives start and both move offers), slave = controller.
interface rps_match_ctrl_if;

   logic       start;
   logic       a_valid;
   logic [2:0] a_move;
   logic       a_ready;
   logic       b_valid;
   logic [2:0] b_move;
   logic       b_ready;
   logic       res_valid;
   logic [1:0] res_code;
   logic [2:0] score_a;
   logic [2:0] score_b;
   logic       match_done;
   logic       match_winner;
   logic       busy;

   modport master (
      output start, a_valid, a_move, b_valid, b_move,
      input  a_ready, b_ready, res_valid, res_code, score_a, score_b,
             match_done, match_winner, busy
   );

   modport slave (
      input  start, a_valid, a_move, b_valid, b_move,
      output a_ready, b_ready, res_valid, res_code, score_a, score_b,
             match_done, match_winner, busy
   );

endinterface

// File: rtl/rps_judge.sv
// Combinational round referee: paper beats rock, rock beats scissors,
// scissors beats paper, equal moves draw, any non-one-hot move voids the round.
module rps_judge
   import rps_pkg::*;
(
   input  logic [2:0] a_move,
   input  logic [2:0] b_move,
   output res_code_e  res_code
);

   logic a_beats_b;

   // Classify the pair; the void check takes priority over everything else.
   always_comb begin
      a_beats_b = ((a_move == MOVE_PAPER)    && (b_move == MOVE_ROCK))     ||
                  ((a_move == MOVE_ROCK)     && (b_move == MOVE_SCISSORS)) ||
                  ((a_move == MOVE_SCISSORS) && (b_move == MOVE_PAPER));
      res_code = RES_DRAW;
      if (!is_legal_move(a_move) || !is_legal_move(b_move)) begin
         res_code = RES_VOID;
      end else if (a_move == b_move) begin
         res_code = RES_DRAW;
      end else if (a_beats_b) begin
         res_code = RES_A_WIN;
      end else begin
         res_code = RES_B_WIN;
      end
   end

endmodule

// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller: collects one move from each player
// per round, judges it, reports the result and tracks the match score up to
// WIN_TARGET round wins.
// Optional feature: define RPS_TIMEOUT_EN to add a per-round move deadline of
// TIMEOUT_CYC cycles (sole submitter wins by forfeit, no submitter voids).
module rps_match_ctrl
   import rps_pkg::*;
#(
   parameter int WIN_TARGET  = 3,
   parameter int TIMEOUT_CYC = 255
)(
   input  logic            clk,
   input  logic            rst,
   rps_match_ctrl_if.slave bus
);

   localparam logic [2:0] WIN_T = 3'(WIN_TARGET);

   state_e     state_q, state_d;
   logic [2:0] a_move_q, a_move_d;
   logic [2:0] b_move_q, b_move_d;
   logic       a_held_q, a_held_d;
   logic       b_held_q, b_held_d;
   logic [2:0] score_a_q, score_a_d;
   logic [2:0] score_b_q, score_b_d;
   res_code_e  res_code_q, res_code_d;
   logic       match_done_q, match_done_d;
   logic       match_winner_q, match_winner_d;

   res_code_e  judge_code;
   res_code_e  round_code;
   logic       timeout_hit;
   logic       a_accept;
   logic       b_accept;

   rps_judge u_judge (
      .a_move   (a_move_q),
      .b_move   (b_move_q),
      .res_code (judge_code)
   );

`ifdef RPS_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   logic [CNT_W-1:0] tcnt_q, tcnt_d;

   // Count cycles spent in COLLECT; any other state zeroes it, so it restarts on entry.
   always_comb begin
      tcnt_d = '0;
      if (state_q == ST_COLLECT) begin
         tcnt_d = tcnt_q + CNT_W'(1);
      end
   end

   assign timeout_hit = (state_q == ST_COLLECT) && (tcnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // After a deadline a lone submitter wins by forfeit; nobody submitting voids the round.
   always_comb begin
      round_code = judge_code;
      if (!(a_held_q && b_held_q)) begin
         if (a_held_q) begin
            round_code = RES_A_WIN;
         end else if (b_held_q) begin
            round_code = RES_B_WIN;
         end else begin
            round_code = RES_VOID;
         end
      end
   end

   // Deadline counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`else
   // No deadline: constant false for any legal TIMEOUT_CYC, COLLECT waits for both moves.
   assign timeout_hit = (TIMEOUT_CYC < 0);
   assign round_code  = judge_code;
`endif

   assign a_accept = (state_q == ST_COLLECT) && !a_held_q && bus.a_valid;
   assign b_accept = (state_q == ST_COLLECT) && !b_held_q && bus.b_valid;

   // Next-state and datapath updates for the match FSM.
   always_comb begin
      state_d        = state_q;
      a_move_d       = a_move_q;
      b_move_d       = b_move_q;
      a_held_d       = a_held_q;
      b_held_d       = b_held_q;
      score_a_d      = score_a_q;
      score_b_d      = score_b_q;
      res_code_d     = res_code_q;
      match_done_d   = match_done_q;
      match_winner_d = match_winner_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d        = ST_COLLECT;
               a_move_d       = '0;
               b_move_d       = '0;
               a_held_d       = 1'b0;
               b_held_d       = 1'b0;
               score_a_d      = '0;
               score_b_d      = '0;
               match_done_d   = 1'b0;
               match_winner_d = 1'b0;
            end
         end
         ST_COLLECT: begin
            if (a_accept) begin
               a_move_d = bus.a_move;
               a_held_d = 1'b1;
            end
            if (b_accept) begin
               b_move_d = bus.b_move;
               b_held_d = 1'b1;
            end
            // Leave only once both latches are already full (or on the deadline).
            if ((a_held_q && b_held_q) || timeout_hit) begin
               state_d = ST_JUDGE;
            end
         end
         ST_JUDGE: begin
            res_code_d = round_code;
            if ((round_code == RES_A_WIN) && (score_a_q < WIN_T)) begin
               score_a_d = score_a_q + 3'd1;
            end
            if ((round_code == RES_B_WIN) && (score_b_q < WIN_T)) begin
               score_b_d = score_b_q + 3'd1;
            end
            state_d = ST_REPORT;
         end
         ST_REPORT: begin
            if ((score_a_q == WIN_T) || (score_b_q == WIN_T)) begin
               state_d        = ST_DONE;
               match_done_d   = 1'b1;
               match_winner_d = (score_b_q == WIN_T);
            end else begin
               state_d  = ST_COLLECT;
               a_held_d = 1'b0;
               b_held_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset returns everything to an idle, empty match.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         a_move_q       <= '0;
         b_move_q       <= '0;
         a_held_q       <= 1'b0;
         b_held_q       <= 1'b0;
         score_a_q      <= '0;
         score_b_q      <= '0;
         res_code_q     <= RES_DRAW;
         match_done_q   <= 1'b0;
         match_winner_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         a_move_q       <= a_move_d;
         b_move_q       <= b_move_d;
         a_held_q       <= a_held_d;
         b_held_q       <= b_held_d;
         score_a_q      <= score_a_d;
         score_b_q      <= score_b_d;
         res_code_q     <= res_code_d;
         match_done_q   <= match_done_d;
         match_winner_q <= match_winner_d;
      end
   end

   assign bus.a_ready      = (state_q == ST_COLLECT) && !a_held_q;
   assign bus.b_ready      = (state_q == ST_COLLECT) && !b_held_q;
   assign bus.res_valid    = (state_q == ST_REPORT);
   assign bus.res_code     = res_code_q;
   assign bus.score_a      = score_a_q;
   assign bus.score_b      = score_b_q;
   assign bus.match_done   = match_done_q;
   assign bus.match_winner = match_winner_q;
   assign bus.busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Self-checking bench for rps_match_ctrl: a round-level model checked every
// cycle, plus directed rounds with literal expected results.
`timescale 1ns/1ps
module tb_rps_match_ctrl;
   import rps_pkg::*;

   localparam int WIN  = 3;
   localparam int TOUT = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rps_match_ctrl_if ifc ();

   rps_match_ctrl #(.WIN_TARGET(WIN), .TIMEOUT_CYC(TOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- round-level model ----------------
   // m_phase: -1 collecting; 0 both moves held; 1 judging; 2 result shown
   int m_active = 0, m_a_got = 0, m_b_got = 0, m_phase = -1;
   int m_sa = 0, m_sb = 0, m_done = 0, m_winner = 0, m_t = 0, m_code = 0;
   logic [2:0] m_am = '0, m_bm = '0;

   function automatic int move_idx(input logic [2:0] m);
      case (m)
         3'b100:  return 0;
         3'b010:  return 1;
         3'b001:  return 2;
         default: return -1;
      endcase
   endfunction

   // paper=0, rock=1, scissors=2: each beats the next index modulo 3
   function automatic int rules(input logic [2:0] am, input logic [2:0] bm);
      int ia, ib, d;
      ia = move_idx(am);
      ib = move_idx(bm);
      if (ia < 0 || ib < 0) return 3;
      d = (ib - ia + 3) % 3;
      if (d == 0) return 0;
      if (d == 1) return 1;
      return 2;
   endfunction

   always @(posedge clk or posedge rst) begin
      bit tout;
      tout = 1'b0;
      if (rst) begin
         m_active = 0; m_a_got = 0; m_b_got = 0; m_phase = -1;
         m_sa = 0; m_sb = 0; m_done = 0; m_winner = 0; m_t = 0; m_code = 0;
      end else if (!m_active) begin
         if (ifc.start) begin
            m_active = 1; m_sa = 0; m_sb = 0; m_done = 0; m_winner = 0;
            m_a_got = 0; m_b_got = 0; m_phase = -1; m_t = 0;
         end
      end else if (m_phase < 0) begin
`ifdef RPS_TIMEOUT_EN
         tout = (m_t == TOUT - 1);
`endif
         if (!m_a_got && ifc.a_valid) begin m_a_got = 1; m_am = ifc.a_move; end
         if (!m_b_got && ifc.b_valid) begin m_b_got = 1; m_bm = ifc.b_move; end
         if (tout) m_phase = 1;
         else if (m_a_got && m_b_got) m_phase = 0;
         m_t++;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (m_a_got && m_b_got) m_code = rules(m_am, m_bm);
         else if (m_a_got) m_code = 1;
         else if (m_b_got) m_code = 2;
         else m_code = 3;
         if (m_code == 1 && m_sa < WIN) m_sa++;
         if (m_code == 2 && m_sb < WIN) m_sb++;
         m_phase = 2;
      end else begin
         if (m_sa == WIN || m_sb == WIN) begin
            m_active = 0; m_done = 1; m_winner = (m_sb == WIN) ? 1 : 0;
         end
         m_a_got = 0; m_b_got = 0; m_phase = -1; m_t = 0;
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_busy", ifc.busy, 0);
         check("rst_a_ready", ifc.a_ready, 0);
         check("rst_b_ready", ifc.b_ready, 0);
         check("rst_res_valid", ifc.res_valid, 0);
         check("rst_res_code", ifc.res_code, 0);
         check("rst_score_a", ifc.score_a, 0);
         check("rst_score_b", ifc.score_b, 0);
         check("rst_done", ifc.match_done, 0);
         check("rst_winner", ifc.match_winner, 0);
      end else begin
         check("busy", ifc.busy, m_active);
         check("a_ready", ifc.a_ready, (m_active && m_phase < 0 && !m_a_got) ? 1 : 0);
         check("b_ready", ifc.b_ready, (m_active && m_phase < 0 && !m_b_got) ? 1 : 0);
         check("res_valid", ifc.res_valid, (m_active && m_phase == 2) ? 1 : 0);
         if (m_active && m_phase == 2) begin
            check("res_code", ifc.res_code, m_code);
            $display("round result: code=%0d score_a=%0d score_b=%0d", ifc.res_code, ifc.score_a, ifc.score_b);
         end
         check("score_a", ifc.score_a, m_sa);
         check("score_b", ifc.score_b, m_sb);
         check("match_done", ifc.match_done, m_done);
         if (m_done) check("match_winner", ifc.match_winner, m_winner);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic do_start();
      ifc.start = 1'b1;
      cyc();
      ifc.start = 1'b0;
   endtask

   // Called in the cycle after the second move was accepted.
   task automatic finish_round(input string name, input int exp_code, input int exp_sa, input int exp_sb);
      int waited;
      waited = 0;
      while (!ifc.res_valid && waited < 30) begin
         cyc();
         waited++;
      end
      if (!ifc.res_valid) begin
         check({name, "_res_timeout"}, 0, 1);
      end else begin
         check({name, "_code"}, ifc.res_code, exp_code);
         check({name, "_score_a"}, ifc.score_a, exp_sa);
         check({name, "_score_b"}, ifc.score_b, exp_sb);
      end
      $display("%s: waited %0d cycles, code=%0d, score %0d-%0d", name, waited, ifc.res_code, ifc.score_a, ifc.score_b);
      cyc();
   endtask

   task automatic play(input string name, input logic [2:0] am, input logic [2:0] bm,
                       input int exp_code, input int exp_sa, input int exp_sb);
      ifc.a_valid = 1'b1; ifc.a_move = am;
      ifc.b_valid = 1'b1; ifc.b_move = bm;
      cyc();
      ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
      cyc();
      check({name, "_pre_res"}, ifc.res_valid, 0);
      cyc();
      check({name, "_latency"}, ifc.res_valid, 1);
      finish_round(name, exp_code, exp_sa, exp_sb);
   endtask

   initial begin
      ifc.start = 1'b0;
      ifc.a_valid = 1'b0; ifc.a_move = '0;
      ifc.b_valid = 1'b0; ifc.b_move = '0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_busy", ifc.busy, 0);
      check("reset_score_a", ifc.score_a, 0);
      check("reset_a_ready", ifc.a_ready, 0);
      rst = 1'b0;
      cyc();
      do_start();
      check("start_busy", ifc.busy, 1);
      check("start_a_ready", ifc.a_ready, 1);

      // A paper vs B rock, three rounds: A takes the match
      play("a_r1", MOVE_PAPER, MOVE_ROCK, 1, 1, 0);
      play("a_r2", MOVE_PAPER, MOVE_ROCK, 1, 2, 0);
      play("a_r3", MOVE_PAPER, MOVE_ROCK, 1, 3, 0);
      check("a_match_done", ifc.match_done, 1);
      check("a_match_winner", ifc.match_winner, 0);
      check("a_done_busy", ifc.busy, 0);
      repeat (3) cyc();
      check("done_hold", ifc.match_done, 1);
      check("done_hold_score", ifc.score_a, 3);

      // restart from DONE clears the scoreboard
      do_start();
      check("restart_score_a", ifc.score_a, 0);
      check("restart_done", ifc.match_done, 0);

      // staggered offers: A rock at cycle 0 (then a changed ignored offer), B rock at cycle 5
      ifc.a_valid = 1'b1; ifc.a_move = MOVE_ROCK;
      cyc();
      ifc.a_move = MOVE_PAPER;
      check("stag_a_ready_low", ifc.a_ready, 0);
      check("stag_b_ready_high", ifc.b_ready, 1);
      repeat (4) cyc();
      ifc.b_valid = 1'b1; ifc.b_move = MOVE_ROCK;
      cyc();
      ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
      check("stag_b_ready_low", ifc.b_ready, 0);
      cyc();
      check("stag_pre_res", ifc.res_valid, 0);
      cyc();
      check("stag_latency", ifc.res_valid, 1);
      finish_round("stagger_draw", 0, 0, 0);

      // start asserted mid-round is ignored; scissors beats paper
      ifc.start = 1'b1;
      play("midstart", MOVE_PAPER, MOVE_SCISSORS, 2, 0, 1);
      ifc.start = 1'b0;

      // illegal move voids the round and play continues
      play("void", 3'b011, MOVE_PAPER, 3, 0, 1);
      check("void_busy", ifc.busy, 1);
      check("void_a_ready", ifc.a_ready, 1);

      play("b_r2", MOVE_SCISSORS, MOVE_ROCK, 2, 0, 2);

      // reset while judging with score_b = 2
      ifc.a_valid = 1'b1; ifc.a_move = MOVE_ROCK;
      ifc.b_valid = 1'b1; ifc.b_move = MOVE_PAPER;
      cyc();
      ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
      cyc();
      check("judge_busy", ifc.busy, 1);
      check("judge_score_b", ifc.score_b, 2);
      rst = 1'b1;
      #1;
      check("async_busy", ifc.busy, 0);
      check("async_score_b", ifc.score_b, 0);
      check("async_res_valid", ifc.res_valid, 0);
      check("async_a_ready", ifc.a_ready, 0);
      check("async_b_ready", ifc.b_ready, 0);
      check("async_res_code", ifc.res_code, 0);
      cyc();
      rst = 1'b0;
      cyc();
      do_start();
      check("fresh_score_a", ifc.score_a, 0);
      check("fresh_score_b", ifc.score_b, 0);
      play("b_m1", MOVE_ROCK, MOVE_PAPER, 2, 0, 1);
      play("b_m2", MOVE_PAPER, MOVE_SCISSORS, 2, 0, 2);
      play("b_m3", MOVE_SCISSORS, MOVE_ROCK, 2, 0, 3);
      check("b_match_done", ifc.match_done, 1);
      check("b_match_winner", ifc.match_winner, 1);

`ifdef RPS_TIMEOUT_EN
      do_start();
      ifc.b_valid = 1'b1; ifc.b_move = MOVE_ROCK;
      cyc();
      ifc.b_valid = 1'b0;
      finish_round("timeout_b_only", 2, 0, 1);
      cyc();
      finish_round("timeout_none", 3, 0, 1);
`endif

      repeat (2) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 100000ns");
      $fatal(1, "watchdog");
   end

endmodule
